// File: rtl/rx_iq_packer_if.sv
// FIFO read side and sample stream of rx_iq_packer.
// The master modport is the packer's side; the slave modport is the environment's side.
interface rx_iq_packer_if;
  logic        i_fifo_empty;
  logic        o_fifo_pull;
  logic [15:0] i_fifo_data;
  logic        o_sample_valid;
  logic        i_sample_ready;
  logic [12:0] o_sample_i;
  logic [12:0] o_sample_q;
  logic        o_sample_flag;

  modport master (
    input  i_fifo_empty, i_fifo_data, i_sample_ready,
    output o_fifo_pull, o_sample_valid, o_sample_i, o_sample_q, o_sample_flag
  );

  modport slave (
    output i_fifo_empty, i_fifo_data, i_sample_ready,
    input  o_fifo_pull, o_sample_valid, o_sample_i, o_sample_q, o_sample_flag
  );
endinterface

// File: rtl/rx_iq_packer.sv
// Pairs framed I/Q modem words from the LVDS RX FIFO into 13-bit I/Q samples on a valid/ready stream.
// Define RX_PACKER_ERRCNT_EN to build the saturating framing-error counter and its clear input.
module rx_iq_packer (
  input  logic                  i_sys_clk,
  input  logic                  i_rst,
  rx_iq_packer_if.master        bus,
  input  logic                  i_err_clear,
  output logic [15:0]           o_err_count,
  output logic [1:0]            o_debug_state
);
  typedef enum logic [1:0] {
    HUNT_I   = 2'b00,
    WAIT_Q   = 2'b01,
    UNUSED_2 = 2'b10,
    UNUSED_3 = 2'b11
  } state_e;

  localparam logic [1:0] TAG_I = 2'b10;
  localparam logic [1:0] TAG_Q = 2'b01;

  state_e      state_q, state_d;
  logic        rd_valid_q;
  logic [12:0] i_hold_q, i_hold_d;
  logic        flag_hold_q, flag_hold_d;
  logic [12:0] out_i_q, out_q_q;
  logic        out_flag_q;
  logic        out_valid_q, out_valid_d;
  logic        load, err_evt, stall, pull;
  logic [1:0]  tag;

  assign tag   = bus.i_fifo_data[15:14];
  assign stall = out_valid_q && !bus.i_sample_ready;
  // Pull only when the output register can take a load two cycles later.
  assign pull  = !bus.i_fifo_empty && !stall && !i_rst;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d     = state_q;
    i_hold_d    = i_hold_q;
    flag_hold_d = flag_hold_q;
    load        = 1'b0;
    err_evt     = 1'b0;
    case (state_q)
      HUNT_I: begin
        if (rd_valid_q) begin
          if (tag == TAG_I) begin
            i_hold_d    = bus.i_fifo_data[13:1];
            flag_hold_d = bus.i_fifo_data[0];
            state_d     = WAIT_Q;
          end else begin
            err_evt = 1'b1;
          end
        end
      end
      WAIT_Q: begin
        if (rd_valid_q) begin
          if (tag == TAG_Q) begin
            load    = 1'b1;
            state_d = HUNT_I;
          end else if (tag == TAG_I) begin
            err_evt     = 1'b1;
            i_hold_d    = bus.i_fifo_data[13:1];
            flag_hold_d = bus.i_fifo_data[0];
          end else begin
            err_evt = 1'b1;
            state_d = HUNT_I;
          end
        end
      end
      default: state_d = HUNT_I;
    endcase
    out_valid_d = load || (out_valid_q && !bus.i_sample_ready);
  end

  always_ff @(posedge i_sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (i_rst) begin
      state_q     <= HUNT_I;
      rd_valid_q  <= 1'b0;
      i_hold_q    <= '0;
      flag_hold_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_valid_q  <= pull;
      i_hold_q    <= i_hold_d;
      flag_hold_q <= flag_hold_d;
      out_valid_q <= out_valid_d;
      if (load) begin
        out_i_q    <= i_hold_q;
        out_q_q    <= bus.i_fifo_data[13:1];
        out_flag_q <= flag_hold_q;
      end
    end
  end

`ifdef RX_PACKER_ERRCNT_EN
  logic [15:0] err_q;

  // Clear wins over a same-cycle error; the count sticks at all-ones.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst || i_err_clear) begin
      err_q <= '0;
    end else if (err_evt && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign o_err_count = err_q;
`else
  logic unused_err;
  assign unused_err  = i_err_clear ^ err_evt;
  assign o_err_count = 16'h0000;
`endif

  assign bus.o_fifo_pull    = pull;
  assign bus.o_sample_valid = out_valid_q;
  assign bus.o_sample_i     = out_i_q;
  assign bus.o_sample_q     = out_q_q;
  assign bus.o_sample_flag  = out_flag_q;
  assign o_debug_state      = state_q;
endmodule

// File: tb/tb_rx_iq_packer.sv
// Scoreboard bench for rx_iq_packer: a word-level pairing model fills the scoreboard at push time,
// a monitor compares every presented sample; a FIFO model feeds words one cycle after each pull.
module tb_rx_iq_packer;
`ifdef RX_PACKER_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] word;
    int          idx;
  } fifo_ent_t;

  typedef struct {
    logic [12:0] i;
    logic [12:0] q;
    logic        flag;
    int          qidx;
  } sample_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clear;
  logic [15:0] err_count;
  logic [1:0]  dbg_state;

  rx_iq_packer_if bus ();

  rx_iq_packer dut (
    .i_sys_clk     (clk),
    .i_rst         (rst),
    .bus           (bus),
    .i_err_clear   (err_clear),
    .o_err_count   (err_count),
    .o_debug_state (dbg_state)
  );

  always #5 clk = ~clk;

  fifo_ent_t   fifo_q[$];
  sample_t     sb[$];
  int          pop_cyc[int];
  int          acc_cyc[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          word_idx = 0;
  int          ready_mode = 1;
  logic        rst_nx = 1'b1;
  logic        clr_nx = 1'b0;
  logic [15:0] pending = 16'h0;

  // Reference model: pairs an I word with the next Q word; everything else is a framing error.
  bit          m_have_i = 1'b0;
  logic [12:0] m_i = '0;
  logic        m_flag = 1'b0;
  int          m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic m_err_inc();
    if (m_err < 65535) m_err++;
  endtask

  task automatic model_word(input logic [15:0] w);
    case (w[15:14])
      2'b10: begin
        if (m_have_i) m_err_inc();
        m_have_i = 1'b1;
        m_i      = w[13:1];
        m_flag   = w[0];
      end
      2'b01: begin
        if (m_have_i) begin
          sb.push_back('{i: m_i, q: w[13:1], flag: m_flag, qidx: word_idx});
          m_have_i = 1'b0;
        end else begin
          m_err_inc();
        end
      end
      default: begin
        m_err_inc();
        m_have_i = 1'b0;
      end
    endcase
  endtask

  task automatic push(input logic [15:0] w, input bit modeled);
    if (modeled) model_word(w);
    fifo_q.push_back('{word: w, idx: word_idx});
    word_idx++;
  endtask

  // One clock: drive inputs after the falling edge, then act on the pull the DUT will register.
  task automatic step();
    fifo_ent_t e;
    @(negedge clk);
    cyc++;
    rst             = rst_nx;
    err_clear       = clr_nx;
    bus.i_fifo_data = pending;
    bus.i_fifo_empty = (fifo_q.size() == 0);
    case (ready_mode)
      0:       bus.i_sample_ready = 1'b0;
      1:       bus.i_sample_ready = 1'b1;
      default: bus.i_sample_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (bus.o_fifo_pull === 1'b1) begin
      if (fifo_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pull_while_empty: pull=1 with FIFO empty (cycle %0d)", cyc);
      end else begin
        e = fifo_q.pop_front();
        pending = e.word;
        pop_cyc[e.idx] = cyc;
      end
    end else begin
      pending = 16'($urandom);
    end
  endtask

  task automatic drain(input int budget);
    int g = 0;
    while ((fifo_q.size() != 0 || sb.size() != 0) && g < budget) begin
      step();
      g++;
    end
    check("drain_in_budget", 32'(g < budget), 32'd1);
    repeat (4) step();
  endtask

  task automatic check_err(input string name);
    check(name, 32'(err_count), ERRCNT_EN ? 32'(m_err) : 32'd0);
  endtask

  // Monitor: compares every presented sample against the scoreboard head, pops on handshake.
  bit shown = 1'b0;
  always begin
    sample_t exp_s;
    @(negedge clk);
    #2;
    if (rst !== 1'b0 || bus.o_sample_valid !== 1'b1) begin
      shown = 1'b0;
    end else if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_sample: I=0x%0h Q=0x%0h flag=%0b with empty scoreboard (cycle %0d)",
               bus.o_sample_i, bus.o_sample_q, bus.o_sample_flag, cyc);
      shown = 1'b0;
    end else begin
      exp_s = sb[0];
      check("sample_iqf", {5'd0, bus.o_sample_i, bus.o_sample_q, bus.o_sample_flag},
            {5'd0, exp_s.i, exp_s.q, exp_s.flag});
      if (!shown) check("latency_from_q_pull", 32'(cyc - pop_cyc[exp_s.qidx]), 32'd2);
      shown = 1'b1;
      if (bus.i_sample_ready === 1'b1) begin
        void'(sb.pop_front());
        acc_cyc.push_back(cyc);
        shown = 1'b0;
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int qidx;
    int g;
    logic [12:0] ri, rq;
    rst                = 1'b1;
    err_clear          = 1'b0;
    bus.i_fifo_empty   = 1'b1;
    bus.i_fifo_data    = 16'h0;
    bus.i_sample_ready = 1'b1;

    // Reset state
    repeat (3) step();
    check("rst_pull", 32'(bus.o_fifo_pull), 32'd0);
    check("rst_valid", 32'(bus.o_sample_valid), 32'd0);
    check("rst_i", 32'(bus.o_sample_i), 32'd0);
    check("rst_q", 32'(bus.o_sample_q), 32'd0);
    check("rst_flag", 32'(bus.o_sample_flag), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_nx = 1'b0;
    repeat (2) step();

    // Single pair
    acc_cyc.delete();
    push(16'h8003, 1'b1);
    push(16'h4004, 1'b1);
    drain(40);
    check("single_count", 32'(acc_cyc.size()), 32'd1);
    check_err("single_err");

    // Back-to-back throughput
    acc_cyc.delete();
    for (int k = 0; k < 8; k++) begin
      push({2'b10, 13'(k * 3 + 5), 1'(k)}, 1'b1);
      push({2'b01, 13'(13'h1F00 - k), 1'b0}, 1'b1);
    end
    drain(80);
    check("b2b_count", 32'(acc_cyc.size()), 32'd8);
    for (int k = 1; k < acc_cyc.size(); k++)
      check("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd2);

    // Backpressure
    acc_cyc.delete();
    ready_mode = 0;
    for (int k = 0; k < 3; k++) begin
      push({2'b10, 13'(13'h1000 + k), 1'b1}, 1'b1);
      push({2'b01, 13'(k + 40), 1'b1}, 1'b1);
    end
    g = 0;
    while (bus.o_sample_valid !== 1'b1 && g < 20) begin
      step();
      g++;
    end
    check("bp_valid_seen", 32'(g < 20), 32'd1);
    repeat (2) step();
    check("bp_pull_stalled", 32'(bus.o_fifo_pull), 32'd0);
    check("bp_state_wait_q", 32'(dbg_state), 32'd1);
    check("bp_words_left", 32'(fifo_q.size()), 32'd3);
    repeat (6) step();
    ready_mode = 1;
    drain(60);
    check("bp_count", 32'(acc_cyc.size()), 32'd3);

    // Misframe and resync
    push(16'h4000, 1'b1);
    push(16'h8002, 1'b1);
    push(16'h8004, 1'b1);
    push(16'h4006, 1'b1);
    drain(40);
    check("misframe_model_err", 32'(m_err), 32'd2);
    check_err("misframe_err");

    // Bad tag in HUNT_I
    push(16'h0000, 1'b1);
    drain(20);
    check_err("hunt_bad_err");

    // Clear and an error in the same cycle
    push(16'h0000, 1'b1);
    step();
    clr_nx = 1'b1;
    step();
    clr_nx = 1'b0;
    m_err = 0;
    repeat (4) step();
    check_err("clear_priority_err");

`ifdef RX_PACKER_ERRCNT_EN
    // Saturation
    for (int k = 0; k < 65535; k++) push(16'h0000, 1'b1);
    drain(70000);
    check("sat_model", 32'(m_err), 32'hFFFF);
    check_err("sat_reach_err");
    push(16'hC000, 1'b1);
    drain(20);
    check_err("sat_hold_err");
`endif

    // Reset while a Q word is in flight
    push(16'h8010, 1'b0);
    qidx = word_idx;
    push(16'h4020, 1'b0);
    g = 0;
    while (!pop_cyc.exists(qidx) && g < 20) begin
      step();
      g++;
    end
    check("rstfl_q_pulled", 32'(g < 20), 32'd1);
    rst_nx = 1'b1;
    step();
    step();
    check("rstfl_valid", 32'(bus.o_sample_valid), 32'd0);
    check("rstfl_i", 32'(bus.o_sample_i), 32'd0);
    check("rstfl_q", 32'(bus.o_sample_q), 32'd0);
    check("rstfl_flag", 32'(bus.o_sample_flag), 32'd0);
    check("rstfl_pull", 32'(bus.o_fifo_pull), 32'd0);
    check("rstfl_state", 32'(dbg_state), 32'd0);
    check("rstfl_err", 32'(err_count), 32'd0);
    rst_nx   = 1'b0;
    m_have_i = 1'b0;
    m_err    = 0;
    fifo_q.delete();
    acc_cyc.delete();
    repeat (6) step();
    check("rstfl_no_sample", 32'(acc_cyc.size()), 32'd0);

    // Randomised traffic with random backpressure
    ready_mode = 2;
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 9) < 8) begin
        ri = 13'($urandom);
        rq = 13'($urandom);
        push({2'b10, ri, 1'($urandom)}, 1'b1);
        push({2'b01, rq, 1'($urandom)}, 1'b1);
      end else begin
        push(16'($urandom), 1'b1);
      end
      repeat ($urandom_range(0, 2)) step();
    end
    drain(3000);
    check_err("random_err");
    check("random_state_idle", 32'(dbg_state), m_have_i ? 32'd1 : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
